// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and data-memory waits,
// with a saved return state so a memory wait resumes whatever stall or flush it interrupted.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_Branch,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [1:0] LS_INIT = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
  localparam logic [1:0] FL_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t     state_reg, state_next;
  state_t     ret_state_reg, ret_state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [1:0] ret_cnt_reg, ret_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic   load_use;
  logic   branch_taken;
  logic   mem_wait;
  logic   flush_inc;
  state_t eff_state;
  logic [1:0] eff_cnt;

  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign branch_taken = ex_Branch && ex_branch_taken;
  assign mem_wait     = mem_req && !mem_ready;

  // Once a memory wait releases, behave exactly as the interrupted state would have.
  assign eff_state = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;
  assign eff_cnt   = (state_reg == MEM_WAIT) ? ret_cnt_reg   : cnt_reg;

  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_write    = 1'b1;
    id_ex_bubble   = 1'b0;
    ex_mem_hold    = 1'b0;
    flush_inc      = 1'b0;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ret_state_next = ret_state_reg;
    ret_cnt_next   = ret_cnt_reg;

    if (reset) begin
      state_next     = RUN;
      cnt_next       = 2'd0;
      ret_state_next = RUN;
      ret_cnt_next   = 2'd0;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
      state_next  = MEM_WAIT;
      if (state_reg != MEM_WAIT) begin
        ret_state_next = state_reg;
        ret_cnt_next   = cnt_reg;
      end
    end else begin
      case (eff_state)
        LOAD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (eff_cnt == 2'd0) begin
            state_next = RUN;
            cnt_next   = 2'd0;
          end else begin
            state_next = LOAD_STALL;
            cnt_next   = eff_cnt - 2'd1;
          end
        end
        FLUSH: begin
          // Branch and load-use inputs belong to squashed instructions here.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (eff_cnt == 2'd0) begin
            state_next = RUN;
            cnt_next   = 2'd0;
          end else begin
            state_next = FLUSH;
            cnt_next   = eff_cnt - 2'd1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 2'd0;
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              cnt_next   = FL_INIT;
            end
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = LOAD_STALL;
              cnt_next   = LS_INIT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      cnt_reg       <= 2'd0;
      ret_state_reg <= RUN;
      ret_cnt_reg   <= 2'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ret_state_reg <= ret_state_next;
      ret_cnt_reg   <= ret_cnt_next;
      if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_events = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: two sequencers (1/1 cycles, 16-bit counters and 2/2 cycles, 3-bit counters)
// share one stimulus stream; each cycle their control vectors are checked against hand values.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_MemRead, ex_Branch, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write, a_id_ex_bubble, a_ex_mem_hold;
  logic [15:0] a_stall_cycles, a_flush_events;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_id_ex_bubble, b_ex_mem_hold;
  logic [2:0]  b_stall_cycles, b_flush_events;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_write(a_id_ex_write), .id_ex_bubble(a_id_ex_bubble), .ex_mem_hold(a_ex_mem_hold),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_write(b_id_ex_write), .id_ex_bubble(b_id_ex_bubble), .ex_mem_hold(b_ex_mem_hold),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_hold
  logic [5:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write, a_id_ex_bubble, a_ex_mem_hold};
  assign b_ctl = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_id_ex_bubble, b_ex_mem_hold};

  localparam logic [5:0] DEF    = 6'b110100;
  localparam logic [5:0] STALL  = 6'b000110;
  localparam logic [5:0] FLSH   = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000001;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_MemRead = 1'b0;
    ex_Branch = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu(input logic [4:0] rd);
    ex_MemRead = 1'b1; ex_rd = rd; id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
  endtask

  task automatic br();
    ex_Branch = 1'b1; ex_branch_taken = 1'b1;
  endtask

  // Called just after a falling edge with inputs already applied: check, then advance one cycle.
  task automatic cyc(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b);
    #1;
    $display("step %-12s a_ctl=%b b_ctl=%b", tag, a_ctl, b_ctl);
    chk({tag, "_a"}, {26'd0, a_ctl}, {26'd0, exp_a});
    chk({tag, "_b"}, {26'd0, b_ctl}, {26'd0, exp_b});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc("rst", DEF, DEF);
    reset = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int as, input int bs, input int af, input int bf);
    chk({tag, "_a_stall"}, {16'd0, a_stall_cycles}, as);
    chk({tag, "_b_stall"}, {29'd0, b_stall_cycles}, bs);
    chk({tag, "_a_flush"}, {16'd0, a_flush_events}, af);
    chk({tag, "_b_flush"}, {29'd0, b_flush_events}, bf);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    // Reset overrides a live hazard
    lu(5'd5);
    cyc("rst_lu", DEF, DEF);
    reset = 1'b0;
    idle();
    chk_cnt("rst", 0, 0, 0, 0);

    // Load-use on rs1
    lu(5'd5);
    cyc("t1_lu", STALL, STALL);
    idle();
    cyc("t1_after", DEF, STALL);
    cyc("t1_idle", DEF, DEF);
    chk_cnt("t1", 1, 2, 0, 0);

    // x0 destination, unused source, non-load, then rs2 match
    do_reset();
    lu(5'd0);
    cyc("t2_x0", DEF, DEF);
    lu(5'd5); id_uses_rs1 = 1'b0;
    cyc("t2_noread", DEF, DEF);
    lu(5'd5); ex_MemRead = 1'b0;
    cyc("t2_noload", DEF, DEF);
    lu(5'd5); id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1; id_rs2 = 5'd5; id_rs1 = 5'd9;
    cyc("t2_rs2", STALL, STALL);
    idle();
    cyc("t2_after", DEF, STALL);
    chk_cnt("t2", 1, 2, 0, 0);

    // Branch: not-taken, taken beating load-use, FLUSH ignoring new events
    do_reset();
    ex_Branch = 1'b1;
    cyc("t3_nt", DEF, DEF);
    br(); lu(5'd5);
    cyc("t3_br", FLSH, FLSH);
    br(); lu(5'd5);
    cyc("t3_br2", FLSH, FLSH);
    idle(); lu(5'd5);
    cyc("t3_lu", STALL, STALL);
    idle();
    cyc("t3_after", DEF, STALL);
    cyc("t3_idle", DEF, DEF);
    chk_cnt("t3", 1, 2, 2, 1);

    // Memory wait beats a branch; 3 freeze cycles then release
    do_reset();
    mem_req = 1'b1; br();
    cyc("t4_w1", FREEZE, FREEZE);
    idle(); mem_req = 1'b1;
    cyc("t4_w2", FREEZE, FREEZE);
    cyc("t4_w3", FREEZE, FREEZE);
    mem_ready = 1'b1;
    cyc("t4_rdy", DEF, DEF);
    idle();
    cyc("t4_idle", DEF, DEF);
    chk_cnt("t4", 3, 3, 0, 0);

    // Memory wait interrupting LOAD_STALL resumes the remaining stall cycle
    do_reset();
    lu(5'd5);
    cyc("t5_lu", STALL, STALL);
    idle(); mem_req = 1'b1;
    cyc("t5_w1", FREEZE, FREEZE);
    cyc("t5_w2", FREEZE, FREEZE);
    mem_ready = 1'b1;
    cyc("t5_rdy", DEF, STALL);
    idle();
    cyc("t5_idle", DEF, DEF);
    chk_cnt("t5", 3, 4, 0, 0);

    // Reset in FLUSH abandons it and clears counters
    do_reset();
    br();
    cyc("t6_br", FLSH, FLSH);
    reset = 1'b1; idle();
    cyc("t6_rst", DEF, DEF);
    reset = 1'b0;
    cyc("t6_idle", DEF, DEF);
    chk_cnt("t6", 0, 0, 0, 0);

    // Memory wait interrupting FLUSH resumes the flush
    br();
    cyc("t8_br", FLSH, FLSH);
    idle(); mem_req = 1'b1;
    cyc("t8_w", FREEZE, FREEZE);
    mem_ready = 1'b1;
    cyc("t8_rdy", DEF, FLSH);
    idle();
    cyc("t8_idle", DEF, DEF);
    chk_cnt("t8", 1, 1, 1, 1);

    // Sustained load-use: narrow counter saturates at 7
    do_reset();
    for (int i = 0; i < 10; i++) begin
      lu(5'd5);
      cyc("t7_lu", STALL, STALL);
    end
    idle();
    cyc("t7_idle", DEF, DEF);
    chk_cnt("t7", 10, 7, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
